// File: rtl/id_hazard_unit.sv
// Decode-stage RAW hazard detector with an in-flight destination scoreboard and redirect flush.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module id_hazard_unit #(
    parameter int PIPE_DEPTH     = 3,
    parameter int REGFILE_BYPASS = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        instr_vld_i,
    input  logic        rd_wren_i,
    input  logic        redirect_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic        bubble_o,
    output logic        flush_ifid_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);
    // With a bypassing register file the WB slot is already readable, so it is excluded.
    localparam int HAZ_SLOTS = PIPE_DEPTH - REGFILE_BYPASS;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] opcode;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;

    logic [PIPE_DEPTH-1:0] slot_vld_q;
    logic [4:0]            slot_rd_q [PIPE_DEPTH];
    logic                  slot0_vld_d;

    wire unused_instr_bits = ^{instr_i[31:25], instr_i[14:12], instr_i[1:0]};

    always_comb begin
        rs1      = instr_i[19:15];
        rs2      = instr_i[24:20];
        rd       = instr_i[11:7];
        opcode   = instr_i[6:2];
        rs1_used = !(opcode == 5'b01101 || opcode == 5'b00101 || opcode == 5'b11011);
        rs2_used = (opcode == 5'b01100 || opcode == 5'b01000 || opcode == 5'b11000);
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (k < HAZ_SLOTS && slot_vld_q[k]) begin
                if (rs1_used && rs1 != 5'd0 && rs1 == slot_rd_q[k]) hazard = 1'b1;
                if (rs2_used && rs2 != 5'd0 && rs2 == slot_rd_q[k]) hazard = 1'b1;
            end
        end
    end

    always_comb begin
        stall_o      = instr_vld_i && hazard && !redirect_i;
        issue_o      = instr_vld_i && !hazard && !redirect_i;
        bubble_o     = !issue_o;
        flush_ifid_o = redirect_i;
        slot0_vld_d  = issue_o && rd_wren_i && (rd != 5'd0);
    end

    // Slot 0 (EX) loads the issuing instruction's destination, or empty on stall/redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_vld_q[0] <= 1'b0;
            slot_rd_q[0]  <= 5'd0;
        end else begin
            slot_vld_q[0] <= slot0_vld_d;
            slot_rd_q[0]  <= issue_o ? rd : 5'd0;
        end
    end

    generate
        for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_slot_shift
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    slot_vld_q[gi] <= 1'b0;
                    slot_rd_q[gi]  <= 5'd0;
                end else begin
                    slot_vld_q[gi] <= slot_vld_q[gi-1];
                    slot_rd_q[gi]  <= slot_rd_q[gi-1];
                end
            end
        end
    endgenerate

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect_i && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit: RAW stall lengths, unused fields, x0, redirect and async reset.
module tb_id_hazard_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_i;
    logic        instr_vld_i;
    logic        rd_wren_i;
    logic        redirect_i;
    logic        stall_o;
    logic        issue_o;
    logic        bubble_o;
    logic        flush_ifid_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    id_hazard_unit dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .instr_i      (instr_i),
        .instr_vld_i  (instr_vld_i),
        .rd_wren_i    (rd_wren_i),
        .redirect_i   (redirect_i),
        .stall_o      (stall_o),
        .issue_o      (issue_o),
        .bubble_o     (bubble_o),
        .flush_ifid_o (flush_ifid_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // Drive one ID-stage cycle: inputs change 2ns after the edge, outputs settle 1ns later.
    task automatic drive(input logic [31:0] ins, input logic vld, input logic wren, input logic redir);
        @(posedge clk_i);
        #2;
        instr_i     = ins;
        instr_vld_i = vld;
        rd_wren_i   = wren;
        redirect_i  = redir;
        #1;
    endtask

    task automatic do_reset;
        rst_ni      = 1'b0;
        instr_i     = 32'd0;
        instr_vld_i = 1'b0;
        rd_wren_i   = 1'b0;
        redirect_i  = 1'b0;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
    endtask

    // Count stall cycles until the held instruction issues, bounded to 10 cycles.
    task automatic run_consumer(input logic [31:0] ins, input logic wren, output int stalls, output logic issued);
        stalls = 0;
        issued = 1'b0;
        for (int c = 0; c < 10 && !issued; c++) begin
            drive(ins, 1'b1, wren, 1'b0);
            if (issue_o) issued = 1'b1;
            else if (stall_o) stalls++;
        end
    endtask

    task automatic test_reset;
        int   stalls;
        logic issued;
        do_reset();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_o !== 1'b0 || issue_o !== 1'b0 || bubble_o !== 1'b1 || flush_ifid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b issue=%b bubble=%b flush=%b required 0 0 1 0",
                     stall_o, issue_o, bubble_o, flush_ifid_o);
        end
        checks++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: stall_cnt=%0d flush_cnt=%0d required 0 0", stall_cnt_o, flush_cnt_o);
        end
        run_consumer(enc_add(5'd2, 5'd1, 5'd1), 1'b1, stalls, issued);
        checks++;
        if (stalls != 0 || !issued) begin
            errors++;
            $display("FAIL reset_no_hazard: stalls=%0d issued=%b required 0 1", stalls, issued);
        end
        $display("reset: stalls=%0d issued=%b", stalls, issued);
    endtask

    task automatic test_adjacent;
        int   stalls;
        logic issued;
        do_reset();
        drive(enc_addi(5'd1, 5'd0, 12'd5), 1'b1, 1'b1, 1'b0);
        checks++;
        if (issue_o !== 1'b1 || bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL adj_producer_issue: issue=%b bubble=%b required 1 0", issue_o, bubble_o);
        end
        run_consumer(enc_add(5'd2, 5'd1, 5'd1), 1'b1, stalls, issued);
        checks++;
        if (stalls != 2 || !issued) begin
            errors++;
            $display("FAIL adj_stall_len: stalls=%0d issued=%b required 2 1", stalls, issued);
        end
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if (stall_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL adj_stall_cnt: got %0d required 2", stall_cnt_o);
        end
`else
        if (stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL adj_stall_cnt: got %0d required 0", stall_cnt_o);
        end
`endif
        $display("adjacent: stalls=%0d issued=%b stall_cnt=%0d", stalls, issued, stall_cnt_o);
    endtask

    task automatic test_distance2;
        int   stalls;
        logic issued;
        do_reset();
        drive(enc_addi(5'd1, 5'd0, 12'd5), 1'b1, 1'b1, 1'b0);
        drive(enc_addi(5'd7, 5'd0, 12'd1), 1'b1, 1'b1, 1'b0);
        checks++;
        if (issue_o !== 1'b1) begin
            errors++;
            $display("FAIL d2_middle_issue: issue=%b required 1", issue_o);
        end
        run_consumer(enc_add(5'd2, 5'd1, 5'd0), 1'b1, stalls, issued);
        checks++;
        if (stalls != 1 || !issued) begin
            errors++;
            $display("FAIL d2_stall_len: stalls=%0d issued=%b required 1 1", stalls, issued);
        end
        $display("distance2: stalls=%0d issued=%b", stalls, issued);
    endtask

    task automatic test_unused_fields;
        int   stalls;
        logic issued;
        do_reset();
        drive(enc_addi(5'd1, 5'd0, 12'd1), 1'b1, 1'b1, 1'b0);
        run_consumer(enc_addi(5'd3, 5'd0, 12'd1), 1'b1, stalls, issued);
        checks++;
        if (stalls != 0 || !issued) begin
            errors++;
            $display("FAIL imm_not_rs2: stalls=%0d issued=%b required 0 1", stalls, issued);
        end
        $display("imm_field: stalls=%0d issued=%b", stalls, issued);
        do_reset();
        drive(enc_addi(5'd1, 5'd0, 12'd1), 1'b1, 1'b1, 1'b0);
        run_consumer(enc_sw(5'd1, 5'd2, 12'd0), 1'b0, stalls, issued);
        checks++;
        if (stalls != 2 || !issued) begin
            errors++;
            $display("FAIL store_rs2: stalls=%0d issued=%b required 2 1", stalls, issued);
        end
        $display("store_rs2: stalls=%0d issued=%b", stalls, issued);
    endtask

    task automatic test_x0;
        int   stalls;
        logic issued;
        do_reset();
        drive(enc_addi(5'd0, 5'd0, 12'd9), 1'b1, 1'b1, 1'b0);
        drive(enc_add(5'd3, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        checks++;
        if (dut.slot_vld_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_slot0: vld=%b required 0", dut.slot_vld_q[0]);
        end
        checks++;
        if (stall_o !== 1'b0 || issue_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_no_stall: stall=%b issue=%b required 0 1", stall_o, issue_o);
        end
        $display("x0: stall=%b issue=%b", stall_o, issue_o);
        // x0-writer followed by a real x0 reader: x3 written by prior add is now the hazard
        run_consumer(enc_add(5'd4, 5'd3, 5'd0), 1'b1, stalls, issued);
        checks++;
        if (stalls != 2 || !issued) begin
            errors++;
            $display("FAIL x0_followup: stalls=%0d issued=%b required 2 1", stalls, issued);
        end
    endtask

    task automatic test_redirect;
        int   stalls;
        logic issued;
        do_reset();
        drive(enc_addi(5'd1, 5'd0, 12'd5), 1'b1, 1'b1, 1'b0);
        drive(enc_add(5'd2, 5'd1, 5'd1), 1'b1, 1'b1, 1'b0);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL redir_pre_stall: stall=%b required 1", stall_o);
        end
        drive(enc_add(5'd2, 5'd1, 5'd1), 1'b1, 1'b1, 1'b1);
        checks++;
        if (stall_o !== 1'b0 || issue_o !== 1'b0 || bubble_o !== 1'b1 || flush_ifid_o !== 1'b1) begin
            errors++;
            $display("FAIL redir_outputs: stall=%b issue=%b bubble=%b flush=%b required 0 0 1 1",
                     stall_o, issue_o, bubble_o, flush_ifid_o);
        end
        $display("redirect: stall=%b issue=%b bubble=%b flush=%b", stall_o, issue_o, bubble_o, flush_ifid_o);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.slot_vld_q[0] !== 1'b0 || flush_ifid_o !== 1'b0 || issue_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_after: slot0=%b flush=%b issue=%b required 0 0 0",
                     dut.slot_vld_q[0], flush_ifid_o, issue_o);
        end
        checks++;
`ifdef HAZARD_PERF_CNT_EN
        if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL redir_cnts: flush_cnt=%0d stall_cnt=%0d required 1 1", flush_cnt_o, stall_cnt_o);
        end
`else
        if (flush_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL redir_cnts: flush_cnt=%0d stall_cnt=%0d required 0 0", flush_cnt_o, stall_cnt_o);
        end
`endif
        // Producer x1 is now in the WB slot, so a fresh reader issues immediately
        run_consumer(enc_add(5'd5, 5'd1, 5'd0), 1'b1, stalls, issued);
        checks++;
        if (stalls != 0 || !issued) begin
            errors++;
            $display("FAIL redir_resume: stalls=%0d issued=%b required 0 1", stalls, issued);
        end
    endtask

    task automatic test_reset_mid_stall;
        int   stalls;
        logic issued;
        do_reset();
        drive(enc_addi(5'd1, 5'd0, 12'd5), 1'b1, 1'b1, 1'b0);
        drive(enc_add(5'd2, 5'd1, 5'd1), 1'b1, 1'b1, 1'b0);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_stall: stall=%b required 1", stall_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || dut.slot_vld_q !== '0 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_async: stall=%b slots=%b stall_cnt=%0d flush_cnt=%0d required 0 0 0 0",
                     stall_o, dut.slot_vld_q, stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        run_consumer(enc_add(5'd2, 5'd1, 5'd1), 1'b1, stalls, issued);
        checks++;
        if (stalls != 0 || !issued) begin
            errors++;
            $display("FAIL rst_resume: stalls=%0d issued=%b required 0 1", stalls, issued);
        end
        $display("reset_mid_stall: stalls=%0d issued=%b", stalls, issued);
    endtask

    initial begin
        test_reset();
        test_adjacent();
        test_distance2();
        test_unused_fields();
        test_x0();
        test_redirect();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
